alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter that shares the single-cycle `alu` between the core execute path (requester 0) and an auxiliary unit (requester 1, e.g. address/compare helper). Each requester has a valid/ready request channel carrying operands and a 4-bit ALU opcode, and a valid/ready response channel fed from a per-requester one-entry result register. The block instantiates one `alu` and arbitrates round-robin, at most one operation per cycle, with fixed 1-cycle latency.

## Interface
- No parameters. Data width is fixed at 32 bits and the opcode at 4 bits, matching `alu`.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_req0_valid` in 1: requester 0 presents an operation.
- `o_req0_ready` out 1: requester 0 operation accepted this cycle.
- `i_req0_op_a` in 32: operand A.
- `i_req0_op_b` in 32: operand B.
- `i_req0_alu_op` in 4: ALU opcode.
- `o_rsp0_valid` out 1: result register 0 holds an undelivered result.
- `i_rsp0_ready` in 1: requester 0 consumes the result.
- `o_rsp0_data` out 32: result for requester 0.
- `i_req1_*`, `o_req1_ready`, `o_rsp1_*`, `i_rsp1_ready`: identical set for requester 1.
- `o_last_grant` out 1: index of the most recently granted requester (round-robin pointer).

## Operation
- Opcodes pass unmodified to `alu`: 0000 ADD, 0001 SUB, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 OR, 0110 AND, 0111 SLL, 1000 SRL, 1001 SRA. Codes 1010–1111 return 0. Shift amount is `op_b[4:0]`.
- Eligibility: `elig_k = i_reqk_valid && (!o_rspk_valid || i_rspk_ready)`. A requester with a full result slot that is not draining this cycle is not eligible.
- Grant (combinational):
  - Only one requester eligible: it wins.
  - Both eligible: the one not equal to `o_last_grant` wins.
  - Neither eligible: no grant.
- `o_reqk_ready = elig_k && grant==k`. Ready may depend on valid; valid must not depend on ready. Requesters hold operands stable while valid && !ready.
- The granted requester's operands and opcode drive the shared `alu` in the same cycle. On the clock edge, the result is written to `o_rspk_data`, `o_rspk_valid` is set to 1, and `o_last_grant` is set to k.
- Response slot k on each edge:
  - Accept k: valid = 1, data = new result. This holds even if the old result drains in the same cycle; no bubble.
  - Else if `o_rspk_valid && i_rspk_ready`: valid = 0, data holds.
  - Else: hold.
- The non-granted requester's slot is unaffected by the other requester's grant.
- `o_rspk_data` is stable while `o_rspk_valid && !i_rspk_ready`.
- Opcodes and results are never altered by arbitration. Results for each requester are returned in issue order; there is one slot per requester, so at most one result is outstanding.

## Timing
- Reset values: `o_rsp0_valid = o_rsp1_valid = 0`, `o_rsp0_data = o_rsp1_data = 0`, `o_last_grant = 1`, so requester 0 wins the first contested cycle. `o_reqk_ready` is combinational; it is 0 whenever `i_reqk_valid = 0`.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). Pending results are discarded and no grant occurs while `i_reset = 1`.
- Latency: request handshake in cycle N → `o_rspk_valid = 1` with data in cycle N+1.
- Throughput: 1 operation per cycle total. A single requester sustains 1 operation per cycle when its `i_rspk_ready` is held high.
- Fairness: under continuous contention with both slots draining, grants strictly alternate. A requester waits at most 1 cycle once eligible.
- Backpressure: a full, non-draining slot k blocks requester k only. The other requester may be granted every cycle.

## Test plan
- **Reset.** Drive random inputs and assert `i_reset`. Required: both `o_rsp_valid = 0`, data = 0, `o_last_grant = 1`, both ready = 0.
- **Single requester.** req0 ADD 5+7, rsp0_ready = 1. Required: ready0 = 1 in cycle N; rsp0_valid = 1 with data = 12 in N+1. Then req0 SRA 0x80000000 by 4 → 0xF8000000.
- **Contention.** Both valid for 4 cycles, both rsp_ready = 1; req0 is SUB 10-3, req1 is SLTU 1,2. Required: grants 0,1,0,1; rsp0 data = 7, rsp1 data = 1.
- **Backpressure.** rsp0 full and rsp0_ready = 0, both requesting. Required: ready0 = 0; requester 1 granted every cycle; rsp0_data held unchanged.
- **Drain and refill.** rsp0 valid holding 12; in the same cycle rsp0_ready = 1 and req0 XOR 0xFF,0x0F is accepted. Required: rsp0_valid stays 1 with data = 0xF0.
- **Reset mid-op.** Both slots valid; assert `i_reset` asynchronously. Required: both valid drop immediately. After release, the first contested grant goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters.
// Each requester owns a one-entry result slot with a valid/ready response channel.
module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  // requester 0
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_op_a,
  input  logic [31:0] i_req0_op_b,
  input  logic [3:0]  i_req0_alu_op,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_data,
  // requester 1
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_op_a,
  input  logic [31:0] i_req1_op_b,
  input  logic [3:0]  i_req1_alu_op,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_data,
  output logic        o_last_grant
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSlt  = 4'd2;
  localparam logic [3:0] OpSltu = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpAnd  = 4'd6;
  localparam logic [3:0] OpSll  = 4'd7;
  localparam logic [3:0] OpSrl  = 4'd8;
  localparam logic [3:0] OpSra  = 4'd9;

  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;
  logic        last_grant_q, last_grant_d;

  logic        elig0, elig1;
  logic        gnt0, gnt1;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;

  // Eligibility and round-robin grant; nothing is granted while reset is held.
  always_comb begin
    elig0 = i_req0_valid && (!rsp0_valid_q || i_rsp0_ready) && !i_reset;
    elig1 = i_req1_valid && (!rsp1_valid_q || i_rsp1_ready) && !i_reset;
    // On contention the requester that did not win last time goes first.
    gnt0  = elig0 && (!elig1 || last_grant_q);
    gnt1  = elig1 && (!elig0 || !last_grant_q);
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  // Operand mux in front of the shared ALU.
  always_comb begin
    alu_a  = i_req0_op_a;
    alu_b  = i_req0_op_b;
    alu_op = i_req0_alu_op;
    if (gnt1) begin
      alu_a  = i_req1_op_a;
      alu_b  = i_req1_op_b;
      alu_op = i_req1_alu_op;
    end
  end

  // Single-cycle ALU; undefined opcodes return zero.
  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      OpAdd:   alu_res = alu_a + alu_b;
      OpSub:   alu_res = alu_a - alu_b;
      OpSlt:   alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      OpSltu:  alu_res = {31'd0, alu_a < alu_b};
      OpXor:   alu_res = alu_a ^ alu_b;
      OpOr:    alu_res = alu_a | alu_b;
      OpAnd:   alu_res = alu_a & alu_b;
      OpSll:   alu_res = alu_a << alu_b[4:0];
      OpSrl:   alu_res = alu_a >> alu_b[4:0];
      OpSra:   alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_res = 32'd0;
    endcase
  end

  // Result slot and round-robin pointer next state; a new result beats a drain.
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    last_grant_d = last_grant_q;
    if (gnt0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_res;
      last_grant_d = 1'b0;
    end else if (rsp0_valid_q && i_rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end
    if (gnt1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_res;
      last_grant_d = 1'b1;
    end else if (rsp1_valid_q && i_rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  // State registers; pointer resets to 1 so requester 0 wins the first contest.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 32'd0;
      rsp1_data_q  <= 32'd0;
      last_grant_q <= 1'b1;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_rsp0_valid = rsp0_valid_q;
  assign o_rsp1_valid = rsp1_valid_q;
  assign o_rsp0_data  = rsp0_data_q;
  assign o_rsp1_data  = rsp1_data_q;
  assign o_last_grant = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors with literal expectations plus a
// transaction-level model compared against every output on every falling edge.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        last_grant;

  int n_checks = 0;
  int n_err    = 0;

  alu_arbiter dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_op_a  (req0_a),
    .i_req0_op_b  (req0_b),
    .i_req0_alu_op(req0_op),
    .o_rsp0_valid (rsp0_valid),
    .i_rsp0_ready (rsp0_ready),
    .o_rsp0_data  (rsp0_data),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_op_a  (req1_a),
    .i_req1_op_b  (req1_b),
    .i_req1_alu_op(req1_op),
    .o_rsp1_valid (rsp1_valid),
    .i_rsp1_ready (rsp1_ready),
    .o_rsp1_data  (rsp1_data),
    .o_last_grant (last_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the opcode table, not from the RTL expressions.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int unsigned sh;
    logic [31:0] ones;
    sh   = b[4:0];
    ones = 32'hFFFF_FFFF;
    case (op)
      4'd0: return a + b;
      4'd1: return a + ~b + 32'd1;
      4'd2: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd3: return {31'd0, a < b};
      4'd4: return a ^ b;
      4'd5: return a | b;
      4'd6: return a & b;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  // Model state: contents of the two result slots and who went last.
  logic        m_v0, m_v1, m_last;
  logic [31:0] m_d0, m_d1;

  // Compare process: inputs are stable from just after a rising edge until the
  // next one, so the model is evaluated and advanced once per falling edge.
  always @(negedge clk) begin
    bit e0, e1;
    int win;
    if (rst) begin
      m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = 32'd0; m_d1 = 32'd0; m_last = 1'b1;
      check("rst ready0", req0_ready, 0);
      check("rst ready1", req1_ready, 0);
    end else begin
      e0  = req0_valid && (!m_v0 || rsp0_ready);
      e1  = req1_valid && (!m_v1 || rsp1_ready);
      win = -1;
      if (e0 && e1) win = (m_last == 1'b1) ? 0 : 1;
      else if (e0)  win = 0;
      else if (e1)  win = 1;
      check("model ready0", req0_ready, (win == 0));
      check("model ready1", req1_ready, (win == 1));
    end
    check("model rsp0_valid", rsp0_valid, m_v0);
    check("model rsp1_valid", rsp1_valid, m_v1);
    check("model rsp0_data", rsp0_data, m_d0);
    check("model rsp1_data", rsp1_data, m_d1);
    check("model last_grant", last_grant, m_last);
    if (!rst) begin
      if (win == 0) begin
        m_v0 = 1'b1; m_d0 = ref_alu(req0_a, req0_b, req0_op); m_last = 1'b0;
      end else if (m_v0 && rsp0_ready) begin
        m_v0 = 1'b0;
      end
      if (win == 1) begin
        m_v1 = 1'b1; m_d1 = ref_alu(req1_a, req1_b, req1_op); m_last = 1'b1;
      end else if (m_v1 && rsp1_ready) begin
        m_v1 = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic rand_reqs();
    set0($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
    set1($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc0, acc1;
    rst = 1'b0;
    set0(1'b0, 32'd0, 32'd0, 4'd0);
    set1(1'b0, 32'd0, 32'd0, 4'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #2 rst = 1'b1;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      step();
      rand_reqs();
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
    end
    set0(1'b1, 32'd1, 32'd2, 4'd0);
    set1(1'b1, 32'd1, 32'd2, 4'd0);
    @(negedge clk);
    check("reset ready0", req0_ready, 0);
    check("reset ready1", req1_ready, 0);
    check("reset last_grant", last_grant, 1);
    check("reset rsp0_data", rsp0_data, 0);
    step();
    rst = 1'b0;
    set0(1'b0, 32'd0, 32'd0, 4'd0);
    set1(1'b0, 32'd0, 32'd0, 4'd0);
    step();

    // Single requester: ADD then SRA.
    rsp0_ready = 1'b1;
    set0(1'b1, 32'd5, 32'd7, 4'd0);
    @(negedge clk);
    check("single ready0", req0_ready, 1);
    step();
    check("single add valid", rsp0_valid, 1);
    check("single add data", rsp0_data, 32'd12);
    set0(1'b1, 32'h8000_0000, 32'd4, 4'd9);
    @(negedge clk);
    check("single sra ready0", req0_ready, 1);
    step();
    check("single sra data", rsp0_data, 32'hF800_0000);

    // Drain, then park 12 in slot 0 and refill it in the draining cycle.
    set0(1'b0, 32'd0, 32'd0, 4'd0);
    step();
    check("drain valid", rsp0_valid, 0);
    rsp0_ready = 1'b0;
    set0(1'b1, 32'd5, 32'd7, 4'd0);
    step();
    set0(1'b0, 32'd0, 32'd0, 4'd0);
    step();
    check("parked valid", rsp0_valid, 1);
    check("parked data", rsp0_data, 32'd12);
    rsp0_ready = 1'b1;
    set0(1'b1, 32'hFF, 32'h0F, 4'd4);
    @(negedge clk);
    check("refill ready0", req0_ready, 1);
    step();
    check("refill valid", rsp0_valid, 1);
    check("refill data", rsp0_data, 32'hF0);

    // Backpressure on slot 0 while requester 1 sweeps every opcode.
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    set0(1'b1, 32'd10, 32'd3, 4'd1);
    for (int op = 0; op < 16; op++) begin
      set1(1'b1, 32'h8000_00F0, 32'h0000_0104, 4'(op));
      @(negedge clk);
      check("bp ready0", req0_ready, 0);
      check("bp ready1", req1_ready, 1);
      step();
      check("bp rsp0_data held", rsp0_data, 32'hF0);
    end
    check("bp last op data", rsp1_data, 32'd0);

    // Reset mid-operation with both slots full.
    check("pre-reset rsp1_valid", rsp1_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async rsp0_valid", rsp0_valid, 0);
    check("async rsp1_valid", rsp1_valid, 0);
    check("async last_grant", last_grant, 1);
    step();
    rst = 1'b0;

    // Contention right after reset: grants alternate starting with 0.
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, 32'd10, 32'd3, 4'd1);
    set1(1'b1, 32'd1, 32'd2, 4'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont ready0", req0_ready, (i % 2 == 0));
      check("cont ready1", req1_ready, (i % 2 == 1));
      step();
      check("cont last_grant", last_grant, i % 2);
      if (i == 0) check("cont rsp0_data", rsp0_data, 32'd7);
      if (i == 1) check("cont rsp1_data", rsp1_data, 32'd1);
    end

    // Random traffic; operands stay put until the request is accepted.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc0 = req0_ready;
      acc1 = req1_ready;
      step();
      if (!req0_valid || acc0)
        set0($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!req1_valid || acc1)
        set1($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
    end

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
